multi_rate_clock_gen: RTL and testbench

Parametrised bank of independent clock dividers producing slow enable/toggle signals from the fast system clock. Each channel has a runtime-loadable divisor, a square-wave or single-cycle-pulse output mode, a per-channel enable, and a common phase-restart input. It supersedes fixed-divisor slow-clock generation for the traffic-light timing chain, supplying timebases for phase timers, blink signals and display scan from one block.

---
 rtl/clk_gen_pkg.sv | 13 +
 rtl/clock_div_channel.sv | 111 +++++++++++
 rtl/multi_rate_clock_gen.sv | 39 +++
 tb/tb_multi_rate_clock_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the multi-rate clock generator.
package clk_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 27;
  // 100 MHz system clock divided to a 1 Hz square wave
  localparam int unsigned DEFAULT_DIV_1HZ = 50_000_000;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: counter, shadow/pending divisor, output mode mux, error flag.
module clock_div_channel
  import clk_gen_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_1HZ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_value_i,
  input  logic             sync_i,
  output logic             out_o,
  output logic             tick_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             tog_q, tog_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] act_m1;
  logic             at_term;
  logic             valid_load;

  always_comb begin
    act_m1     = act_q - 1'b1;
    // >= rather than == so a divisor swapped in while disabled cannot wrap
    at_term    = (cnt_q >= act_m1);
    valid_load = load_i && (div_value_i != '0);

    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tog_d  = tog_q;
    tick_d = 1'b0;
    err_d  = err_q;

    if (load_i) begin
      if (valid_load) begin
        shd_d  = div_value_i;
        pend_d = 1'b1;
        err_d  = 1'b0;
      end else begin
        err_d  = 1'b1;
      end
    end

    if (sync_i) begin
      cnt_d  = '0;
      tog_d  = 1'b0;
      pend_d = 1'b0;
      if (valid_load)  act_d = div_value_i;
      else if (pend_q) act_d = shd_q;
    end else if (en_i) begin
      if (at_term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        pend_d = 1'b0;
        if (mode_i == MODE_SQUARE) tog_d = ~tog_q;
        if (valid_load)  act_d = div_value_i;
        else if (pend_q) act_d = shd_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pend_q) begin
      // disabled: the older pending value moves in now; a same-cycle load stays pending
      act_d = shd_q;
      if (!valid_load) pend_d = 1'b0;
    end

    if (sync_i)                    out_d = 1'b0;
    else if (mode_i == MODE_PULSE) out_d = tick_d;
    else                           out_d = tog_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      act_q  <= DEFAULT_DIV;
      shd_q  <= DEFAULT_DIV;
      pend_q <= 1'b0;
      tog_q  <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tog_q  <= tog_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;
  assign err_o  = err_q;

endmodule

// File: rtl/multi_rate_clock_gen.sv
// Bank of NUM_CH independent runtime-loadable clock dividers sharing sync and div_value.
module multi_rate_clock_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic              clk,
  input  logic              resetSW,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              sync,
  output logic [NUM_CH-1:0] outsignal,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_err
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (resetSW),
      .en_i       (en[g]),
      .mode_i     (mode_e'(mode[g])),
      .load_i     (div_load[g]),
      .div_value_i(div_value),
      .sync_i     (sync),
      .out_o      (outsignal[g]),
      .tick_o     (tick[g]),
      .err_o      (div_err[g])
    );
  end

endmodule

// File: tb/tb_multi_rate_clock_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a period-level model.
module tb_multi_rate_clock_gen;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned DDIV = 5;

  logic            clk = 1'b0;
  logic            resetSW;
  logic [NCH-1:0]  en, mode, div_load;
  logic [CW-1:0]   div_value;
  logic            sync;
  logic [NCH-1:0]  outsignal, tick, div_err;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // model: cycles elapsed in current period, current/queued divisor, toggle, outputs
  int unsigned pos[NCH], cur[NCH], nxt[NCH];
  bit          has_nxt[NCH], tog[NCH], tk[NCH], er[NCH], om[NCH];

  multi_rate_clock_gen #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clk      (clk),
    .resetSW  (resetSW),
    .en       (en),
    .mode     (mode),
    .div_load (div_load),
    .div_value(div_value),
    .sync     (sync),
    .outsignal(outsignal),
    .tick     (tick),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      pos[c] = 0; cur[c] = DDIV; nxt[c] = 0; has_nxt[c] = 0;
      tog[c] = 0; tk[c] = 0; er[c] = 0; om[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NCH; c++) begin
      bit          ld  = div_load[c];
      int unsigned v   = int'(div_value);
      bit          val = ld && (v != 0);
      if (ld) er[c] = (v == 0) ? 1'b1 : 1'b0;
      tk[c] = 0;
      if (sync) begin
        if (val) cur[c] = v;
        else if (has_nxt[c]) cur[c] = nxt[c];
        has_nxt[c] = 0; pos[c] = 0; tog[c] = 0;
        if (val) nxt[c] = v;
      end else if (en[c]) begin
        pos[c]++;
        if (pos[c] >= cur[c]) begin
          pos[c] = 0; tk[c] = 1;
          if (!mode[c]) tog[c] = ~tog[c];
          if (val) cur[c] = v;
          else if (has_nxt[c]) cur[c] = nxt[c];
          has_nxt[c] = 0;
          if (val) nxt[c] = v;
        end else if (val) begin
          nxt[c] = v; has_nxt[c] = 1;
        end
      end else begin
        if (has_nxt[c]) begin cur[c] = nxt[c]; has_nxt[c] = 0; end
        if (val) begin nxt[c] = v; has_nxt[c] = 1; end
      end
      om[c] = sync ? 1'b0 : (mode[c] ? tk[c] : tog[c]);
    end
  endfunction

  function automatic logic [NCH-1:0] pack(input int sel);
    logic [NCH-1:0] r = '0;
    for (int c = 0; c < NCH; c++)
      r[c] = (sel == 0) ? om[c] : (sel == 1) ? tk[c] : er[c];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("outsignal", 32'(outsignal), 32'(pack(0)));
    chk("tick",      32'(tick),      32'(pack(1)));
    chk("div_err",   32'(div_err),   32'(pack(2)));
    div_load = '0;
    sync     = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [NCH-1:0] m, input int unsigned v);
    div_load  = m;
    div_value = CW'(v);
    step();
  endtask

  initial begin
    resetSW = 1'b1; en = '0; mode = '0; div_load = '0; div_value = '0; sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",  32'(outsignal), 32'h0);
    chk("rst_tick", 32'(tick),      32'h0);
    chk("rst_err",  32'(div_err),   32'h0);
    resetSW = 1'b0;
    en = '1;

    // default divisor: ticks/toggles at edges 5, 10, 15
    run(16);

    // mid-period shrink on ch0, zero load then valid load on ch2
    model_reset(); resetSW = 1'b1; #1; resetSW = 1'b0;
    run(2);
    load(4'b0001, 3);
    run(12);
    load(4'b0100, 0);
    run(6);
    load(4'b0100, 4);
    run(10);

    // ch1 pulse mode at divide-by-1, pause and resume
    mode[1] = 1'b1;
    load(4'b0010, 1);
    run(8);
    en[1] = 1'b0;
    run(4);
    en[1] = 1'b1;
    run(4);
    mode[1] = 1'b0;

    // channels at 3 and 7, sync mid-count, then load+sync
    load(4'b0001, 3);
    load(4'b1000, 7);
    run(16);
    sync = 1'b1;
    step();
    run(9);
    div_load = 4'b0010; div_value = CW'(2); sync = 1'b1;
    step();
    run(8);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 49) == 0) mode[c] = ~mode[c];
        div_load[c] = ($urandom_range(0, 24) == 0);
      end
      div_value = CW'($urandom_range(0, 9));
      sync = ($urandom_range(0, 99) == 0);
      step();
    end

    // asynchronous reset between edges once some output is high
    en = '1; mode = '0;
    for (int i = 0; i < 40 && outsignal == '0; i++) step();
    #2;
    resetSW = 1'b1;
    #1;
    model_reset();
    chk("arst_out",  32'(outsignal), 32'h0);
    chk("arst_tick", 32'(tick),      32'h0);
    chk("arst_err",  32'(div_err),   32'h0);
    @(posedge clk); #1;
    resetSW = 1'b0;
    run(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
